// File: rtl/text_console_ctrl.sv
// Console command sequencer for the CPU-side (port A) of the character frame buffer.
// Handles put-char, clear, set-cursor, and the one-line scroll-up that follows a bottom-row newline.
module text_console_ctrl #(
  parameter int         H_SIZE    = 80,
  parameter int         V_SIZE    = 60,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         RD_LAT    = 2
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_char,
  input  logic [6:0]  cmd_col,
  input  logic [5:0]  cmd_row,
  output logic [12:0] fb_adrs,
  output logic [7:0]  fb_wdata,
  output logic        fb_we,
  input  logic [7:0]  fb_rdata,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  localparam logic [6:0] COL_MAX  = 7'(H_SIZE - 1);
  localparam logic [5:0] ROW_MAX  = 6'(V_SIZE - 1);
  localparam int         LW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

  localparam logic [1:0] OP_PUTC   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SETCUR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUT     = 3'd1,
    SC_RD   = 3'd2,
    SC_WR   = 3'd3,
    SC_FILL = 3'd4,
    CLR     = 3'd5
  } state_t;

  state_t        state, state_next;
  logic [6:0]    col_next;
  logic [5:0]    row_next;
  logic [12:0]   adrs_next;
  logic [7:0]    wdata_next;
  logic          we_next;
  logic [5:0]    walk_row, walk_row_next;
  logic [6:0]    walk_col, walk_col_next;
  logic [LW-1:0] lat_cnt, lat_cnt_next;
  logic          sc_pend, sc_pend_next;
  logic          scroll_go;

  // Handshake: a command transfers on the cpu_clk edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and the command fields are sampled only on that edge.
  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign state_dbg = state;

  always_comb begin
    state_next    = state;
    col_next      = cursor_col;
    row_next      = cursor_row;
    adrs_next     = fb_adrs;
    wdata_next    = fb_wdata;
    we_next       = 1'b0;
    walk_row_next = walk_row;
    walk_col_next = walk_col;
    lat_cnt_next  = lat_cnt;
    sc_pend_next  = sc_pend;
    scroll_go     = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUTC: begin
              case (cmd_char)
                8'h08: if (cursor_col != 7'd0) col_next = cursor_col - 7'd1;
                8'h0D: col_next = 7'd0;
                8'h0A: begin
                  col_next = 7'd0;
                  if (cursor_row == ROW_MAX) scroll_go = 1'b1;
                  else row_next = cursor_row + 6'd1;
                end
                default: begin
                  state_next = PUT;
                  we_next    = 1'b1;
                  adrs_next  = {cursor_row, cursor_col};
                  wdata_next = cmd_char;
                  if (cursor_col == COL_MAX) begin
                    col_next = 7'd0;
                    if (cursor_row == ROW_MAX) sc_pend_next = 1'b1;
                    else row_next = cursor_row + 6'd1;
                  end else begin
                    col_next = cursor_col + 7'd1;
                  end
                end
              endcase
            end
            OP_CLEAR: begin
              state_next    = CLR;
              we_next       = 1'b1;
              adrs_next     = 13'd0;
              wdata_next    = FILL_CHAR;
              walk_row_next = 6'd0;
              walk_col_next = 7'd0;
            end
            OP_SETCUR: begin
              col_next = (cmd_col > COL_MAX) ? COL_MAX : cmd_col;
              row_next = (cmd_row > ROW_MAX) ? ROW_MAX : cmd_row;
            end
            default: ;
          endcase
        end
      end

      // The cursor already advanced on acceptance; only the scroll decision is left.
      PUT: begin
        sc_pend_next = 1'b0;
        if (sc_pend) scroll_go = 1'b1;
        else state_next = IDLE;
      end

      SC_RD: begin
        if (lat_cnt == LAT_LAST) begin
          state_next   = SC_WR;
          we_next      = 1'b1;
          adrs_next    = {walk_row - 6'd1, walk_col};
          wdata_next   = fb_rdata;
          lat_cnt_next = '0;
        end else begin
          lat_cnt_next = lat_cnt + 1'b1;
        end
      end

      SC_WR: begin
        if (walk_col == COL_MAX) begin
          walk_col_next = 7'd0;
          if (walk_row == ROW_MAX) begin
            state_next = SC_FILL;
            we_next    = 1'b1;
            adrs_next  = {ROW_MAX, 7'd0};
            wdata_next = FILL_CHAR;
          end else begin
            state_next    = SC_RD;
            walk_row_next = walk_row + 6'd1;
            adrs_next     = {walk_row + 6'd1, 7'd0};
          end
        end else begin
          state_next    = SC_RD;
          walk_col_next = walk_col + 7'd1;
          adrs_next     = {walk_row, walk_col + 7'd1};
        end
      end

      SC_FILL: begin
        if (walk_col == COL_MAX) begin
          state_next = IDLE;
        end else begin
          walk_col_next = walk_col + 7'd1;
          we_next       = 1'b1;
          adrs_next     = {ROW_MAX, walk_col + 7'd1};
          wdata_next    = FILL_CHAR;
        end
      end

      CLR: begin
        if (walk_col == COL_MAX) begin
          walk_col_next = 7'd0;
          if (walk_row == ROW_MAX) begin
            state_next = IDLE;
            col_next   = 7'd0;
            row_next   = 6'd0;
          end else begin
            walk_row_next = walk_row + 6'd1;
            we_next       = 1'b1;
            adrs_next     = {walk_row + 6'd1, 7'd0};
          end
        end else begin
          walk_col_next = walk_col + 7'd1;
          we_next       = 1'b1;
          adrs_next     = {walk_row, walk_col + 7'd1};
        end
      end

      default: state_next = IDLE;
    endcase

    // Scroll starts by presenting the first source cell, row 1 column 0.
    if (scroll_go) begin
      state_next    = SC_RD;
      walk_row_next = 6'd1;
      walk_col_next = 7'd0;
      lat_cnt_next  = '0;
      adrs_next     = {6'd1, 7'd0};
      we_next       = 1'b0;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cursor_col <= 7'd0;
      cursor_row <= 6'd0;
      fb_adrs    <= 13'd0;
      fb_wdata   <= 8'd0;
      fb_we      <= 1'b0;
      walk_row   <= 6'd0;
      walk_col   <= 7'd0;
      lat_cnt    <= '0;
      sc_pend    <= 1'b0;
    end else begin
      state      <= state_next;
      cursor_col <= col_next;
      cursor_row <= row_next;
      fb_adrs    <= adrs_next;
      fb_wdata   <= wdata_next;
      fb_we      <= we_next;
      walk_row   <= walk_row_next;
      walk_col   <= walk_col_next;
      lat_cnt    <= lat_cnt_next;
      sc_pend    <= sc_pend_next;
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: vector table for single commands, scoreboard of expected
// frame-buffer writes, and hand sequences for clear, scroll, held NOP and mid-clear reset.
module tb_text_console_ctrl;

  localparam int H = 80;
  localparam int V = 60;

  logic        cpu_clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_char;
  logic [6:0]  cmd_col;
  logic [5:0]  cmd_row;
  logic [12:0] fb_adrs;
  logic [7:0]  fb_wdata;
  logic        fb_we;
  logic [7:0]  fb_rdata;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;
  logic [2:0]  state_dbg;

  text_console_ctrl #(.H_SIZE(H), .V_SIZE(V), .FILL_CHAR(8'h20), .RD_LAT(2)) dut (
    .cpu_clk(cpu_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_char(cmd_char), .cmd_col(cmd_col), .cmd_row(cmd_row),
    .fb_adrs(fb_adrs), .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_rdata(fb_rdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // frame buffer: synchronous write, one registered read stage (2 cycles from address)
  logic [7:0] mem [0:8191];
  always @(posedge cpu_clk) begin
    if (fb_we) mem[fb_adrs] <= fb_wdata;
    fb_rdata <= mem[fb_adrs];
  end

  // scoreboard
  logic [20:0] exp_q[$];
  logic [7:0]  model [0:8191];
  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  logic count_only = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge cpu_clk) begin
    if (fb_we) begin
      if (count_only) begin
        wr_count++;
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got adrs %0h data %0h expected none", fb_adrs, fb_wdata);
      end else begin
        check("write", 32'({fb_adrs, fb_wdata}), 32'(exp_q.pop_front()));
      end
      check("write_in_range", 32'((fb_adrs[6:0] < 7'(H)) && (fb_adrs[12:7] < 6'(V))), 32'd1);
    end
  end

  // driver tasks
  task automatic push_write(input logic [5:0] r, input logic [6:0] c, input logic [7:0] d);
    exp_q.push_back({r, c, d});
    model[{r, c}] = d;
  endtask

  task automatic push_scroll();
    for (int r = 1; r < V; r++)
      for (int c = 0; c < H; c++)
        push_write(6'(r - 1), 7'(c), model[{6'(r), 7'(c)}]);
    for (int c = 0; c < H; c++) push_write(6'(V - 1), 7'(c), 8'h20);
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] ch,
                      input logic [6:0] col, input logic [5:0] row);
    @(negedge cpu_clk);
    cmd_op = op; cmd_char = ch; cmd_col = col; cmd_row = row;
    cmd_valid = 1'b1;
    @(posedge cpu_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int cyc);
    cyc = 0;
    while (!cmd_ready && cyc < budget) begin
      @(posedge cpu_clk);
      #1;
      cyc++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle_timeout: got busy after %0d cycles expected idle", cyc);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] ch;
    logic [6:0] col;
    logic [5:0] row;
    logic [6:0] e_col;
    logic [5:0] e_row;
    int         e_busy;
    logic       e_wr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int cyc;
    int bad;
    logic [6:0] p_col;
    logic [5:0] p_row;

    vecs[0]  = '{2'b00, 8'h41, 7'd0,   6'd0,  7'd1,  6'd0,  1, 1'b1};
    vecs[1]  = '{2'b10, 8'h00, 7'd79,  6'd5,  7'd79, 6'd5,  0, 1'b0};
    vecs[2]  = '{2'b00, 8'h42, 7'd0,   6'd0,  7'd0,  6'd6,  1, 1'b1};
    vecs[3]  = '{2'b10, 8'h00, 7'd100, 6'd63, 7'd79, 6'd59, 0, 1'b0};
    vecs[4]  = '{2'b00, 8'h0D, 7'd0,   6'd0,  7'd0,  6'd59, 0, 1'b0};
    vecs[5]  = '{2'b00, 8'h08, 7'd0,   6'd0,  7'd0,  6'd59, 0, 1'b0};
    vecs[6]  = '{2'b10, 8'h00, 7'd10,  6'd3,  7'd10, 6'd3,  0, 1'b0};
    vecs[7]  = '{2'b00, 8'h08, 7'd0,   6'd0,  7'd9,  6'd3,  0, 1'b0};
    vecs[8]  = '{2'b00, 8'h0A, 7'd0,   6'd0,  7'd0,  6'd4,  0, 1'b0};
    vecs[9]  = '{2'b11, 8'h41, 7'd5,   6'd5,  7'd0,  6'd4,  0, 1'b0};
    vecs[10] = '{2'b00, 8'h7E, 7'd0,   6'd0,  7'd1,  6'd4,  1, 1'b1};
    vecs[11] = '{2'b10, 8'h00, 7'd127, 6'd0,  7'd79, 6'd0,  0, 1'b0};
    vecs[12] = '{2'b00, 8'h0A, 7'd0,   6'd0,  7'd0,  6'd1,  0, 1'b0};

    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_char = 8'h00; cmd_col = 7'd0; cmd_row = 6'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(fb_we), 32'd0);
    check("rst_adrs", 32'(fb_adrs), 32'd0);
    check("rst_wdata", 32'(fb_wdata), 32'd0);
    check("rst_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    rst_n = 1'b1;

    // single-command vectors
    p_col = 7'd0; p_row = 6'd0;
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].e_wr) push_write(p_row, p_col, vecs[i].ch);
      send(vecs[i].op, vecs[i].ch, vecs[i].col, vecs[i].row);
      wait_idle(100, cyc);
      check($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_col", i), 32'(cursor_col), 32'(vecs[i].e_col));
      check($sformatf("vec%0d_row", i), 32'(cursor_row), 32'(vecs[i].e_row));
      p_col = vecs[i].e_col; p_row = vecs[i].e_row;
    end
    check("table_writes_done", 32'(exp_q.size()), 32'd0);

    // full-screen clear
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++) push_write(6'(r), 7'(c), 8'h20);
    send(2'b01, 8'h00, 7'd0, 6'd0);
    wait_idle(10000, cyc);
    check("clear_busy_cycles", 32'(cyc), 32'(V * H));
    check("clear_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    check("clear_writes_done", 32'(exp_q.size()), 32'd0);
    check("clear_adrs_hold", 32'(fb_adrs), 32'({6'd59, 7'd79}));
    check("clear_we_low", 32'(fb_we), 32'd0);

    // preload row1 col0 then LF on the bottom row
    send(2'b10, 8'h00, 7'd0, 6'd1);
    push_write(6'd1, 7'd0, 8'h55);
    send(2'b00, 8'h55, 7'd0, 6'd0);
    wait_idle(100, cyc);
    send(2'b10, 8'h00, 7'd0, 6'd59);
    push_scroll();
    send(2'b00, 8'h0A, 7'd0, 6'd0);
    wait_idle(20000, cyc);
    check("lf_scroll_busy_cycles", 32'(cyc), 32'd14240);
    check("lf_scroll_cursor", 32'({cursor_row, cursor_col}), 32'({6'd59, 7'd0}));
    check("lf_scroll_writes_done", 32'(exp_q.size()), 32'd0);
    check("scroll_row0_col0", 32'(mem[{6'd0, 7'd0}]), 32'h55);
    bad = 0;
    for (int c = 0; c < H; c++) if (mem[{6'd59, 7'(c)}] !== 8'h20) bad++;
    check("scroll_row59_fill", 32'(bad), 32'd0);

    // glyph in the bottom-right cell: write, wrap, then scroll
    send(2'b10, 8'h00, 7'd79, 6'd59);
    push_write(6'd59, 7'd79, 8'h5A);
    push_scroll();
    send(2'b00, 8'h5A, 7'd0, 6'd0);
    wait_idle(20000, cyc);
    check("wrap_scroll_busy_cycles", 32'(cyc), 32'd14241);
    check("wrap_scroll_cursor", 32'({cursor_row, cursor_col}), 32'({6'd59, 7'd0}));
    check("wrap_scroll_writes_done", 32'(exp_q.size()), 32'd0);
    check("wrap_scroll_row58_col79", 32'(mem[{6'd58, 7'd79}]), 32'h5A);

    // NOP held on cmd_valid: ready never drops, no writes
    send(2'b10, 8'h00, 7'd20, 6'd7);
    @(negedge cpu_clk);
    cmd_op = 2'b11; cmd_char = 8'h41; cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge cpu_clk);
      if (!cmd_ready) bad++;
    end
    cmd_valid = 1'b0;
    check("nop_hold_ready", 32'(bad), 32'd0);
    check("nop_hold_cursor", 32'({cursor_row, cursor_col}), 32'({6'd7, 7'd20}));

    // reset in the middle of a clear
    count_only = 1'b1;
    wr_count = 0;
    send(2'b01, 8'h00, 7'd0, 6'd0);
    repeat (100) @(negedge cpu_clk);
    #1;
    rst_n = 1'b0;
    @(posedge cpu_clk);
    #1;
    count_only = 1'b0;
    check("midclr_write_count", 32'(wr_count), 32'd100);
    check("midclr_we", 32'(fb_we), 32'd0);
    check("midclr_ready", 32'(cmd_ready), 32'd1);
    check("midclr_cursor", 32'({cursor_row, cursor_col}), 32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge cpu_clk);
    check("midclr_still_idle", 32'(cmd_ready), 32'd1);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
